// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port AHB arbiter: round-robin address-phase grant held across bursts and locked
// sequences, plus registered data-phase owner. Optional starvation limit: AHB_ARB_STARVE_LIMIT_EN.
module ahb_slave_port_arbiter #(
  parameter int NO_OF_MASTERS = 4,
  parameter int ID_W          = $clog2(NO_OF_MASTERS)
`ifdef AHB_ARB_STARVE_LIMIT_EN
  ,
  parameter int STARVE_LIMIT  = 16
`endif
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [NO_OF_MASTERS-1:0]   req_i,
  input  logic [2*NO_OF_MASTERS-1:0] htrans_i,
  input  logic [NO_OF_MASTERS-1:0]   hmastlock_i,
  input  logic                       hready_i,
  output logic [NO_OF_MASTERS-1:0]   grant_o,
  output logic [ID_W-1:0]            addr_owner_o,
  output logic                       hsel_o,
  output logic                       hmastlock_o,
  output logic [ID_W-1:0]            data_owner_o,
  output logic                       data_valid_o
`ifdef AHB_ARB_STARVE_LIMIT_EN
  ,
  output logic                       starve_o
`endif
);

  // Transfer-type encoding used on this interconnect.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OWNED  = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          data_owner_q;
  logic                     data_valid_q;

  logic [ID_W-1:0]          winner_idx;
  logic                     winner_found;
  logic [ID_W-1:0]          cand;
  logic [1:0]               own_trans;
  logic                     own_req;
  logic                     own_lock;
  logic                     others_req;
  logic                     release_c;
  logic                     take_winner;
  logic                     preempt;

  assign own_trans  = htrans_i[{owner_q, 1'b0} +: 2];
  assign own_req    = req_i[owner_q];
  assign own_lock   = hmastlock_i[owner_q];
  assign others_req = |(req_i & ~grant_q);
  assign release_c  = !own_req || ((own_trans == HTRANS_IDLE) && !own_lock);

  // Round-robin scan starting just after the last winner; the current owner is
  // rr_ptr_q itself, so it is naturally visited last.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    winner_found = 1'b0;
    winner_idx   = '0;
    cand         = '0;
    for (int k = 1; k <= NO_OF_MASTERS; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NO_OF_MASTERS);
      if (!winner_found && req_i[cand]) begin
        winner_found = 1'b1;
        winner_idx   = cand;
      end
    end
  end

`ifdef AHB_ARB_STARVE_LIMIT_EN
  localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        starve_q;

  // Forced handover only on a fresh transfer or idle slot, never inside a burst.
  assign preempt = (starve_cnt_q >= LIMIT) && others_req &&
                   ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_IDLE));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_d != grant_q) begin
      starve_cnt_d = '0;
    end else if (hready_i && others_req && (state_q != ST_IDLE) &&
                 (starve_cnt_q != 16'hFFFF)) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d == LIMIT) && (starve_cnt_q != LIMIT);
    end
  end

  assign starve_o = starve_q;
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    take_winner = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (winner_found) take_winner = 1'b1;
      end
      ST_OWNED: begin
        if (hready_i) begin
          if (release_c || preempt) begin
            if (others_req) take_winner = 1'b1;
            else            state_d     = ST_IDLE;
          end else if (own_lock) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (hready_i && !own_lock) state_d = ST_OWNED;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_winner) begin
      owner_d  = winner_idx;
      rr_ptr_d = winner_idx;
      state_d  = hmastlock_i[winner_idx] ? ST_LOCKED : ST_OWNED;
    end

    grant_d = '0;
    if (state_d != ST_IDLE) grant_d[owner_d] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on hresetn low.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= ID_W'(NO_OF_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Data phase follows the address phase only when the slave accepts it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else if (hready_i) begin
      data_owner_q <= owner_q;
      data_valid_q <= hsel_o && own_trans[1];
    end
  end

  assign grant_o      = grant_q;
  assign addr_owner_o = owner_q;
  assign hsel_o       = (|grant_q) && own_req;
  assign hmastlock_o  = hsel_o && own_lock;
  assign data_owner_o = data_owner_q;
  assign data_valid_o = data_valid_q;

  grant_onehot_a: assert property (@(posedge hclk) disable iff (!hresetn) $onehot0(grant_q));

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for ahb_slave_port_arbiter: round-robin order, burst/lock hold, data phase, reset.
module tb_ahb_slave_port_arbiter;

  localparam int N = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_SEQ    = 2'b10;
  localparam logic [1:0] T_NONSEQ = 2'b11;

  logic           hclk    = 1'b0;
  logic           hresetn = 1'b0;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [1:0]     tr [N];
  logic [2*N-1:0] htrans;
  logic           hready;
  logic [N-1:0]   grant;
  logic [1:0]     addr_owner;
  logic [1:0]     data_owner;
  logic           hsel;
  logic           hmastlock;
  logic           data_valid;
`ifdef AHB_ARB_STARVE_LIMIT_EN
  logic           starve;
`endif

  int total = 0;
  int bad   = 0;

  assign htrans = {tr[3], tr[2], tr[1], tr[0]};

  always #5 hclk = ~hclk;

  ahb_slave_port_arbiter #(
    .NO_OF_MASTERS(N)
`ifdef AHB_ARB_STARVE_LIMIT_EN
    ,
    .STARVE_LIMIT (4)
`endif
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req_i       (req),
    .htrans_i    (htrans),
    .hmastlock_i (lock),
    .hready_i    (hready),
    .grant_o     (grant),
    .addr_owner_o(addr_owner),
    .hsel_o      (hsel),
    .hmastlock_o (hmastlock),
    .data_owner_o(data_owner),
    .data_valid_o(data_valid)
`ifdef AHB_ARB_STARVE_LIMIT_EN
    ,
    .starve_o    (starve)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    req    = '0;
    lock   = '0;
    hready = 1'b1;
    for (int m = 0; m < N; m++) tr[m] = T_IDLE;
  endtask

  // Called just after an edge: reset must clear outputs without waiting for a clock.
  task automatic do_reset();
    hresetn = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_dvalid", 32'(data_valid), 32'h0);
    check("rst_downer", 32'(data_owner), 32'h0);
    idle_inputs();
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    idle_inputs();
    #3;
    check("init_grant", 32'(grant), 32'h0);
    check("init_aowner", 32'(addr_owner), 32'h0);
    check("init_downer", 32'(data_owner), 32'h0);
    check("init_dvalid", 32'(data_valid), 32'h0);
    check("init_hsel", 32'(hsel), 32'h0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;

    // Two requesters, all IDLE: master 0 first, then master 2, then nobody.
    req = 4'b0101;
    tick();
    check("t1_grant0", 32'(grant), 32'h1);
    check("t1_aowner0", 32'(addr_owner), 32'h0);
    check("t1_hsel", 32'(hsel), 32'h1);
    tick();
    check("t1_grant2", 32'(grant), 32'h4);
    check("t1_aowner2", 32'(addr_owner), 32'h2);
    check("t1_dvalid", 32'(data_valid), 32'h0);
    req = 4'b0000;
    tick();
    check("t1_grant_none", 32'(grant), 32'h0);
    check("t1_hsel_none", 32'(hsel), 32'h0);

    // All four request; each owner does one NONSEQ then IDLE.
    do_reset();
    req = 4'b1111;
    for (int m = 0; m < N; m++) tr[m] = T_NONSEQ;
    tick();
    check("rr_first", 32'(grant), 32'h1);
    for (int i = 0; i < 8; i++) begin
      e = i % N;
      tr[e] = T_NONSEQ;
      tick();
      check("rr_hold", 32'(grant), 32'h1 << e);
      check("rr_dvalid", 32'(data_valid), 32'h1);
      check("rr_downer", 32'(data_owner), 32'(e));
      check("rr_hmastlock", 32'(hmastlock), 32'h0);
      tr[e] = T_IDLE;
      tick();
      check("rr_next", 32'(grant), 32'h1 << ((e + 1) % N));
      check("rr_dvalid_idle", 32'(data_valid), 32'h0);
      tr[e] = T_NONSEQ;
    end

    // Master 1 INCR4 with wait states while master 2 requests.
    do_reset();
    req = 4'b0010;
    tick();
    check("b_grant1", 32'(grant), 32'h2);
    req   = 4'b0110;
    tr[2] = T_NONSEQ;
    tr[1] = T_NONSEQ;
    tick();
    check("b_beat1", 32'(grant), 32'h2);
    check("b_dvalid1", 32'(data_valid), 32'h1);
    check("b_downer1", 32'(data_owner), 32'h1);
    tr[1] = T_SEQ;
    tick();
    check("b_beat2", 32'(grant), 32'h2);
    hready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      check("b_wait_grant", 32'(grant), 32'h2);
      check("b_wait_dvalid", 32'(data_valid), 32'h1);
    end
    hready = 1'b1;
    tick();
    check("b_beat3", 32'(grant), 32'h2);
    tick();
    check("b_beat4", 32'(grant), 32'h2);
    tr[1]  = T_IDLE;
    hready = 1'b0;
    tick();
    check("b_idle_wait", 32'(grant), 32'h2);
    hready = 1'b1;
    tick();
    check("b_handover", 32'(grant), 32'h4);
    check("b_aowner", 32'(addr_owner), 32'h2);

    // Master 3 locked and idling while masters 0 and 1 request.
    do_reset();
    req     = 4'b1000;
    lock[3] = 1'b1;
    tick();
    check("l_grant3", 32'(grant), 32'h8);
    check("l_hmastlock", 32'(hmastlock), 32'h1);
    req = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("l_hold", 32'(grant), 32'h8);
    end
    req = 4'b0011;
    tick();
    check("l_hold_noreq", 32'(grant), 32'h8);
    req     = 4'b1011;
    lock[3] = 1'b0;
    tick();
    check("l_unlock", 32'(grant), 32'h8);
    tick();
    check("l_release", 32'(grant), 32'h1);

    // Data phase waits for hready.
    do_reset();
    req = 4'b0100;
    tick();
    check("d_grant2", 32'(grant), 32'h4);
    tr[2]  = T_NONSEQ;
    hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("d_wait_owner", 32'(data_owner), 32'h0);
      check("d_wait_valid", 32'(data_valid), 32'h0);
    end
    hready = 1'b1;
    tick();
    check("d_owner", 32'(data_owner), 32'h2);
    check("d_valid", 32'(data_valid), 32'h1);
    tr[2] = T_IDLE;
    tick();
    check("d_idle_valid", 32'(data_valid), 32'h0);
    check("d_idle_owner", 32'(data_owner), 32'h2);

`ifdef AHB_ARB_STARVE_LIMIT_EN
    // Master 0 streams NONSEQ singles while master 1 waits.
    do_reset();
    req   = 4'b0011;
    tr[0] = T_NONSEQ;
    tr[1] = T_NONSEQ;
    tick();
    check("sv_grant0", 32'(grant), 32'h1);
    check("sv_starve0", 32'(starve), 32'h0);
    for (int b = 1; b <= 3; b++) begin
      tick();
      check("sv_hold", 32'(grant), 32'h1);
      check("sv_quiet", 32'(starve), 32'h0);
    end
    tick();
    check("sv_pulse", 32'(starve), 32'h1);
    check("sv_pulse_grant", 32'(grant), 32'h1);
    tick();
    check("sv_handover", 32'(grant), 32'h2);
    check("sv_pulse_end", 32'(starve), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
